// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory between instruction
// fetch and load/store, with a three-state sequencer and a saturating contention counter.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [7:0]    conflicts
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    logic [1:0] state;
    logic       owner;
    logic       last_grant;
    logic       cmd_we;
    logic       start;
    logic       pick_d;
    logic       contend;
    logic       resp;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Data wins alone, or under contention when fetch took the previous grant.
    always_comb begin
        contend = if_req & d_req;
        start   = ~halt & (if_req | d_req);
        pick_d  = d_req & (~if_req | (last_grant == OWN_IF));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_D;
            cmd_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            conflicts  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_ISSUE;
                        owner      <= pick_d;
                        last_grant <= pick_d;
                        cmd_we     <= pick_d & d_we;
                        mem_addr   <= pick_d ? d_addr : if_addr;
                        mem_wdata  <= pick_d ? d_wdata : '0;
                        if (contend)
                            conflicts <= sat_inc(conflicts);
                    end
                end
                S_ISSUE: state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them without a clock.
    always_comb begin
        mem_en   = (state == S_ISSUE);
        mem_we   = mem_en & cmd_we & (owner == OWN_D);
        busy     = (state != S_IDLE);
        resp     = (state == S_RESP);
        if_ack   = resp & (owner == OWN_IF);
        d_ack    = resp & (owner == OWN_D);
        if_rdata = if_ack ? mem_rdata : '0;
        d_rdata  = d_ack ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected acks,
// a negedge monitor pops and compares them against a behavioural memory.
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
    } d_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic [7:0]  conflicts;

    logic [15:0] tbmem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    logic [15:0] exp_if[$];
    d_exp_t      exp_d[$];
    byte         glog[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          if_ack_cyc = -1;
    int          d_ack_cyc = -1;
    int          c0;

    mem_arbiter #(.AW(8), .DW(16)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre_en)
            tbmem[pre_addr] <= pre_data;
        else if (mem_en) begin
            if (mem_we)
                tbmem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= tbmem[mem_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit port_d, input string nm);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = port_d ? d_ack : if_ack;
        end
        check(nm, {31'd0, got}, 32'd1);
    endtask

    task automatic push_d(input logic we, input logic [7:0] a, input logic [15:0] v);
        d_exp_t e;
        e.we = we;
        e.addr = a;
        e.data = v;
        exp_d.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every ack, checks rdata is zero otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_ack) begin
                if_ack_cyc = cyc;
                glog.push_back(8'h49);
                if (exp_if.size() == 0)
                    check("if_spurious_ack", {31'd0, if_ack}, 32'd0);
                else
                    check("if_rdata", {16'd0, if_rdata}, {16'd0, exp_if.pop_front()});
            end else
                check("if_rdata_idle", {16'd0, if_rdata}, 32'd0);
            if (d_ack) begin
                d_exp_t e;
                d_ack_cyc = cyc;
                glog.push_back(8'h44);
                if (exp_d.size() == 0)
                    check("d_spurious_ack", {31'd0, d_ack}, 32'd0);
                else begin
                    e = exp_d.pop_front();
                    if (e.we)
                        check("store_mem", {16'd0, tbmem[e.addr]}, {16'd0, e.data});
                    else
                        check("d_rdata", {16'd0, d_rdata}, {16'd0, e.data});
                end
            end else
                check("d_rdata_idle", {16'd0, d_rdata}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Preload memory while the DUT sits in reset.
        pre_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin pre_addr = 8'h10; pre_data = 16'hABCD; end
                1: begin pre_addr = 8'h30; pre_data = 16'h5A5A; end
                2: begin pre_addr = 8'h40; pre_data = 16'h0F0F; end
                default: begin pre_addr = 8'h50; pre_data = 16'h1111; end
            endcase
            tick();
        end
        pre_en = 1'b0;

        // Reset with random requests.
        for (int i = 0; i < 5; i++) begin
            if_req = 1'($urandom_range(0, 1));
            d_req = 1'($urandom_range(0, 1));
            d_we = 1'($urandom_range(0, 1));
            if_addr = 8'($urandom);
            d_addr = 8'($urandom);
            d_wdata = 16'($urandom);
            @(negedge clk);
            check("rst_ctrl", {27'd0, busy, mem_en, mem_we, if_ack, d_ack}, 32'd0);
            check("rst_cmd", {8'd0, mem_addr, mem_wdata}, 32'd0);
            check("rst_rdata", {if_rdata, d_rdata}, 32'd0);
            check("rst_conflicts", {24'd0, conflicts}, 32'd0);
        end

        // Contention at the first edge after reset: fetch first, data 3 cycles later.
        tick();
        if_req = 1'b1; if_addr = 8'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
        exp_if.push_back(16'h5A5A);
        push_d(1'b0, 8'h40, 16'h0F0F);
        reset = 1'b0;
        tick();
        c0 = cyc;
        fork
            begin wait_ack(1'b0, "ct_if_ack"); tick(); if_req = 1'b0; end
            begin wait_ack(1'b1, "ct_d_ack"); tick(); d_req = 1'b0; end
        join
        check("ct_if_cycle", if_ack_cyc, c0 + 1);
        check("ct_d_cycle", d_ack_cyc, c0 + 4);
        check("ct_conflicts", {24'd0, conflicts}, 32'd1);

        // Both held: grants alternate I, D, I, D.
        glog.delete();
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_if.push_back(16'h5A5A);
            push_d(1'b0, 8'h40, 16'h0F0F);
        end
        @(posedge clk);
        repeat (11) @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        check("alt_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check("alt_order", {24'd0, glog[i]}, (i % 2 == 0) ? 32'h49 : 32'h44);
        check("alt_conflicts", {24'd0, conflicts}, 32'd5);

        // Single fetch with cycle-exact timing.
        tick();
        if_req = 1'b1; if_addr = 8'h10;
        exp_if.push_back(16'hABCD);
        @(posedge clk);
        @(negedge clk);
        check("sf_issue", {23'd0, mem_en, mem_we, busy, d_ack, mem_addr}, {23'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10});
        @(negedge clk);
        check("sf_resp", {28'd0, if_ack, d_ack, mem_en, busy}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b1});
        tick();
        if_req = 1'b0;

        // Store then load back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'h1234;
        push_d(1'b1, 8'h20, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        check("st_issue", {6'd0, mem_en, mem_we, mem_addr, mem_wdata}, {6'd0, 1'b1, 1'b1, 8'h20, 16'h1234});
        @(negedge clk);
        check("st_ack", {30'd0, d_ack, if_ack}, 32'd2);
        tick();
        d_we = 1'b0; d_wdata = 16'h0000;
        push_d(1'b0, 8'h20, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        check("ld_issue", {22'd0, mem_en, mem_we, mem_addr}, {22'd0, 1'b1, 1'b0, 8'h20});
        @(negedge clk);
        check("ld_ack", {30'd0, d_ack, mem_we}, 32'd2);
        tick();
        d_req = 1'b0;

        // Halt blocks grants while IDLE.
        halt = 1'b1; if_req = 1'b1; if_addr = 8'h50;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_block", {30'd0, mem_en, busy}, 32'd0);
        end
        tick();
        halt = 1'b0;
        exp_if.push_back(16'h1111);
        @(posedge clk);
        @(negedge clk);
        check("halt_release_grant", {31'd0, mem_en}, 32'd1);
        wait_ack(1'b0, "halt_release_ack");
        tick();
        if_req = 1'b0;

        // Halt rising during ISSUE does not abort the access.
        tick();
        if_req = 1'b1; if_addr = 8'h10;
        exp_if.push_back(16'hABCD);
        @(posedge clk);
        #1;
        halt = 1'b1;
        wait_ack(1'b0, "halt_inflight_ack");
        tick();
        if_req = 1'b0;
        tick();
        halt = 1'b0;

        // Async reset during ISSUE: outputs drop without a clock, no ack follows.
        tick();
        if_req = 1'b1; if_addr = 8'h10;
        @(posedge clk);
        #1;
        check("ar_pre_issue", {31'd0, mem_en}, 32'd1);
        reset = 1'b1;
        #1;
        check("ar_drop", {29'd0, mem_en, busy, if_ack}, 32'd0);
        check("ar_conflicts", {24'd0, conflicts}, 32'd0);
        if_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ar_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
        end

        // 300 contended arbitrations saturate the counter at 255.
        tick();
        if_req = 1'b1; if_addr = 8'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
        for (int i = 0; i < 150; i++) begin
            exp_if.push_back(16'h5A5A);
            push_d(1'b0, 8'h40, 16'h0F0F);
        end
        @(posedge clk);
        repeat (899) @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        check("sat_conflicts", {24'd0, conflicts}, 32'd255);

        repeat (4) @(negedge clk);
        check("sb_if_drained", exp_if.size(), 0);
        check("sb_d_drained", exp_d.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
